// File: rtl/taus_sched.sv
`timescale 1ns/1ps
// taus_sched: seeds and warms up a Tausworthe generator, then hands its
// words out round-robin, one per grant, to two level-requesters A and B.
module taus_sched #(
    parameter int unsigned WARMUP = 16,
    parameter int unsigned W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         seed_req,
    output logic         taus_ld,
    output logic         taus_en,
    input  logic [W-1:0] taus_out,
    input  logic         a_req,
    input  logic         b_req,
    output logic         a_ack,
    output logic         b_ack,
    output logic [W-1:0] a_data,
    output logic [W-1:0] b_data,
    output logic         ready,
    output logic [15:0]  issued_cnt
);
    localparam int unsigned CNTW = 16;
    localparam int unsigned WCW  = 8;
    localparam logic [WCW-1:0] WARM_LAST = (WARMUP == 0) ? '0 : WCW'(WARMUP - 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [WCW-1:0] warm_cnt, warm_n;
    logic           last_b;
    logic           grant_a, grant_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            warm_cnt <= '0;
        end else begin
            state    <= state_n;
            warm_cnt <= warm_n;
        end
    end

    // seed_req pre-empts both warm-up stepping and grants in the same cycle
    always_comb begin
        state_n = state;
        warm_n  = warm_cnt;
        taus_ld = 1'b0;
        taus_en = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            INIT: state_n = LOAD;
            LOAD: begin
                taus_ld = 1'b1;
                warm_n  = '0;
                state_n = (WARMUP == 0) ? RUN : WARM;
            end
            WARM: begin
                if (seed_req) begin
                    state_n = LOAD;
                end else begin
                    taus_en = 1'b1;
                    if (warm_cnt == WARM_LAST) begin
                        state_n = RUN;
                    end else begin
                        warm_n = warm_cnt + WCW'(1);
                    end
                end
            end
            RUN: begin
                if (seed_req) begin
                    state_n = LOAD;
                end else begin
                    grant_a = a_req & (~b_req | last_b);
                    grant_b = b_req & (~a_req | ~last_b);
                    taus_en = grant_a | grant_b;
                end
            end
            default: state_n = INIT;
        endcase
    end

    assign ready = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_data     <= '0;
            b_data     <= '0;
            last_b     <= 1'b1;
            issued_cnt <= '0;
        end else begin
            a_ack <= grant_a;
            b_ack <= grant_b;
            if (grant_a) begin
                a_data <= taus_out;
            end
            if (grant_b) begin
                b_data <= taus_out;
            end
            if (grant_a | grant_b) begin
                last_b <= grant_b;
            end
            if (state_n == LOAD) begin
                issued_cnt <= '0;
            end else if (grant_a | grant_b) begin
                issued_cnt <= issued_cnt + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_taus_sched.sv
`timescale 1ns/1ps
// Bench for taus_sched: cycle-level reference model plus directed scenarios
// with hand-computed expectations.
module tb_taus_sched;
    localparam int unsigned W      = 32;
    localparam int unsigned WARMUP = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic seed_req = 1'b0;
    logic a_req = 1'b0;
    logic b_req = 1'b0;
    logic taus_ld, taus_en, a_ack, b_ack, ready;
    logic [W-1:0] taus_out, a_data, b_data;
    logic [15:0]  issued_cnt;

    int total = 0;
    int bad   = 0;

    taus_sched #(.WARMUP(WARMUP), .W(W)) dut (
        .clk(clk), .reset(reset), .seed_req(seed_req),
        .taus_ld(taus_ld), .taus_en(taus_en), .taus_out(taus_out),
        .a_req(a_req), .b_req(b_req), .a_ack(a_ack), .b_ack(b_ack),
        .a_data(a_data), .b_data(b_data), .ready(ready), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // stand-in generator: xorshift32, a fresh seed on every load
    logic [W-1:0] gen    = 32'h1234_5678;
    logic [W-1:0] seed_v = 32'h9E37_79B9;
    assign taus_out = gen;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    always @(posedge clk) begin
        if (taus_ld) begin
            gen    <= seed_v;
            seed_v <= xs(seed_v ^ 32'hA5A5_0F0F);
        end else if (taus_en) begin
            gen <= xs(gen);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: phase 0=INIT 1=LOAD 2=WARM 3=RUN
    int           m_phase  = 0;
    int           m_wc     = 0;
    bit           m_last_b = 1'b1;
    bit           m_aack   = 1'b0;
    bit           m_back   = 1'b0;
    logic [W-1:0] m_ad     = '0;
    logic [W-1:0] m_bd     = '0;
    int           m_cnt    = 0;
    bit           seen [logic [W-1:0]];

    always @(negedge clk) begin
        bit run, sd, ga, gb;
        if (reset) begin
            m_phase = 0; m_wc = 0; m_last_b = 1'b1;
            m_aack = 1'b0; m_back = 1'b0; m_ad = '0; m_bd = '0; m_cnt = 0;
        end
        run = (m_phase == 3);
        sd  = seed_req && (m_phase >= 2) && !reset;
        ga  = run && !sd && a_req && (!b_req || m_last_b);
        gb  = run && !sd && b_req && (!a_req || !m_last_b);
        chk("m_ld",    taus_ld,    64'(m_phase == 1));
        chk("m_en",    taus_en,    64'((m_phase == 2 && !sd) || ga || gb));
        chk("m_ready", ready,      64'(run));
        chk("m_aack",  a_ack,      64'(m_aack));
        chk("m_back",  b_ack,      64'(m_back));
        chk("m_adata", a_data,     64'(m_ad));
        chk("m_bdata", b_data,     64'(m_bd));
        chk("m_cnt",   issued_cnt, 64'(m_cnt));
        if (!reset) begin
            m_aack = ga;
            m_back = gb;
            if (ga || gb) begin
                chk("m_unique", 64'(seen.exists(taus_out)), 64'(0));
                seen[taus_out] = 1'b1;
                if (ga) m_ad = taus_out;
                if (gb) m_bd = taus_out;
                m_last_b = gb;
                m_cnt = (m_cnt + 1) % 65536;
            end
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_wc = 0;
                    m_phase = (WARMUP == 0) ? 3 : 2;
                end
                2: begin
                    if (sd) m_phase = 1;
                    else if (m_wc == int'(WARMUP) - 1) m_phase = 3;
                    else m_wc++;
                end
                default: if (sd) m_phase = 1;
            endcase
            if (m_phase == 1) m_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called in cycle 0 (INIT) right after reset release, with a_req held high
    task automatic startup();
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) tick();
            chk("start_ld",    taus_ld, 64'(c == 1));
            if (c < 19) chk("start_en", taus_en, 64'(c >= 2));
            chk("start_ready", ready,   64'(c >= 18));
            chk("start_aack",  a_ack,   64'(c == 19));
            chk("start_back",  b_ack,   64'(0));
        end
    endtask

    logic [W-1:0] w [8];
    int n;

    initial begin
        repeat (3) tick();
        chk("rst_ld",    taus_ld,    64'(0));
        chk("rst_ready", ready,      64'(0));
        chk("rst_cnt",   issued_cnt, 64'(0));
        a_req = 1'b1;
        reset = 1'b0;
        startup();

        // both requesting; A won last (startup), so B leads the alternation
        b_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            chk("alt_a", a_ack, 64'(i % 2 == 1));
            chk("alt_b", b_ack, 64'(i % 2 == 0));
            w[i] = a_ack ? a_data : b_data;
        end
        // one startup word plus eight alternating words
        chk("alt_cnt", issued_cnt, 64'(9));
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                chk("alt_distinct", 64'(w[i] == w[j]), 64'(0));

        // A alone: back-to-back delivery every cycle
        a_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("solo_aack", a_ack, 64'(1));
            chk("solo_back", b_ack, 64'(0));
            if (i < 5) chk("solo_en", taus_en, 64'(1));
            else a_req = 1'b0;
        end

        // reseed while both request
        tick();
        a_req = 1'b1;
        b_req = 1'b1;
        seed_req = 1'b1;
        chk("seed_en", taus_en, 64'(0));
        tick();
        seed_req = 1'b0;
        chk("seed_ld",   taus_ld,    64'(1));
        chk("seed_aack", a_ack,      64'(0));
        chk("seed_back", b_ack,      64'(0));
        chk("seed_cnt",  issued_cnt, 64'(0));
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rewarm_en",    taus_en, 64'(1));
            chk("rewarm_ready", ready,   64'(0));
            chk("rewarm_ack",   64'(a_ack | b_ack), 64'(0));
        end
        tick();
        chk("resume_ready", ready, 64'(1));
        chk("resume_ack",   64'(a_ack | b_ack), 64'(0));
        tick();
        // A was granted last before the reseed, so B goes first
        chk("resume_b", b_ack, 64'(1));
        chk("resume_a", a_ack, 64'(0));
        b_req = 1'b0;

        // reset in the middle of warm-up, warm_cnt == 7
        tick();
        seed_req = 1'b1;
        tick();
        seed_req = 1'b0;
        repeat (8) tick();
        #1 reset = 1'b1;
        #1;
        chk("mid_ld",    taus_ld,    64'(0));
        chk("mid_en",    taus_en,    64'(0));
        chk("mid_ready", ready,      64'(0));
        chk("mid_ack",   64'(a_ack | b_ack), 64'(0));
        chk("mid_adata", a_data,     64'(0));
        chk("mid_bdata", b_data,     64'(0));
        chk("mid_cnt",   issued_cnt, 64'(0));
        repeat (2) tick();
        reset = 1'b0;
        startup();

        // counter wrap: A held until the count reaches 0xFFFE
        n = 0;
        while (issued_cnt != 16'hFFFE && n < 70000) begin
            tick();
            n++;
        end
        chk("wrap_reach", 64'(issued_cnt == 16'hFFFE), 64'(1));
        tick();
        chk("wrap_ffff", issued_cnt, 64'h0000_FFFF);
        tick();
        chk("wrap_0000", issued_cnt, 64'h0000_0000);
        tick();
        chk("wrap_0001", issued_cnt, 64'h0000_0001);
        a_req = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/taus_sched.md
TAUS_SCHED -- requirements
Module: taus_sched

Interface
REQ-001 The block SHALL have parameter WARMUP, default 16, which sets the number of generator steps discarded after each seed load (legal range 0..255).
REQ-002 The block SHALL have parameter W, default 32, which sets the width of the generator word.
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 seed_req  in  1  single-cycle pulse requesting a reseed/restart of the generator.
REQ-006 taus_ld  out  1  strobe that loads the seed into the Tausworthe generator.
REQ-007 taus_en  out  1  strobe that advances the generator by one step.
REQ-008 taus_out  in  W  current generator output word, valid every cycle.
REQ-009 a_req / b_req  in  1 each  level request for one word per grant.
REQ-010 a_ack / b_ack  out  1 each  one-cycle strobe marking a_data / b_data valid.
REQ-011 a_data / b_data  out  W each  delivered word.
REQ-012 ready  out  1  high when in RUN.
REQ-013 issued_cnt  out  16  count of words delivered since the last seed load.

Function
REQ-014 The FSM SHALL have the states INIT, LOAD, WARM and RUN, and the state SHALL be registered.
REQ-015 INIT SHALL transition to LOAD on the first clock edge after reset deasserts.
REQ-016 taus_ld SHALL be high exactly when the state is LOAD, and LOAD SHALL last 1 cycle.
REQ-017 On exit from LOAD, the FSM SHALL go to WARM with warm_cnt=0, or directly to RUN if WARMUP=0.
REQ-018 In WARM, taus_en SHALL be 1 every cycle and warm_cnt SHALL increment each cycle; the FSM SHALL go to RUN on the edge where warm_cnt==WARMUP-1.
REQ-019 In RUN, at most one grant SHALL be issued per cycle: grant_a = a_req and (not b_req or last==B), and grant_b is the complement among the requesters.
REQ-020 In RUN, taus_en SHALL equal grant_a or grant_b, combinationally in the grant cycle.
REQ-021 On the grant edge, x_ack SHALL be set to 1 and x_data SHALL capture taus_out (latency: request sampled in cycle N, ack and data visible in cycle N+1).
REQ-022 x_ack SHALL be high for exactly 1 cycle per word.
REQ-023 x_data SHALL hold its last value until the next grant to that requester.
REQ-024 A requester that keeps its req high during its ack cycle SHALL be eligible for another word in that same cycle (back-to-back delivery).
REQ-025 Round-robin pointer last SHALL update to the granted requester, and SHALL reset to B so that A wins the first contention.
REQ-026 issued_cnt SHALL increment by 1 per grant, SHALL wrap from 0xFFFF to 0x0000, and SHALL clear to 0 on entry to LOAD.
REQ-027 seed_req in WARM or RUN SHALL force the next state to LOAD, SHALL take priority over any grant in the same cycle (no ack, no taus_en), and SHALL restart warm-up.
REQ-028 seed_req in INIT or LOAD SHALL be ignored.
REQ-029 taus_ld and taus_en SHALL never both be high in the same cycle.
REQ-030 Outside RUN, requests SHALL be held off: no ack is issued, and the pending req remains pending.
REQ-031 The block SHALL never deliver the same generator word twice and SHALL never deliver a word produced during LOAD or WARM.

Reset
REQ-032 While reset is high, the state SHALL be INIT, and taus_ld, taus_en, a_ack, b_ack, ready, a_data, b_data, issued_cnt, warm_cnt SHALL be 0, with last=B.
REQ-033 Reset asserted in any state, including mid-WARM or mid-grant, SHALL abort immediately (asynchronously), and the sequence SHALL restart from INIT after deassertion.

Verification
REQ-034 Reset release, WARMUP=16 -> taus_ld high in cycle 1, taus_en high in cycles 2..17, ready rises in cycle 18, with no ack before cycle 18.
REQ-035 RUN with a_req=b_req=1 held for 8 cycles -> acks alternate A,B,A,B..., each data equals taus_out of its grant cycle, all 8 words are distinct, and issued_cnt=8.
REQ-036 RUN with a_req held and b_req=0 -> a_ack high every cycle and taus_en high every cycle, with b_ack never asserted.
REQ-037 seed_req pulse in RUN while both requests are high -> no ack in that cycle, taus_ld next cycle, 16 warm cycles, issued_cnt=0, then grants resume with A first only if last=B.
REQ-038 reset asserted at warm_cnt=7 -> all outputs 0 within the same cycle, and after release the full INIT, LOAD, 16-cycle WARM sequence repeats.
REQ-039 Force issued_cnt to 0xFFFE and make 3 grants -> issued_cnt reads 0xFFFF, then 0x0000, then 0x0001.
